control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that sits directly upstream of the datapath and drives its per-step control strobes. It sequences instruction fetch (T0-T2), decodes IR[31:27], and runs execute steps (T3-T6) for three-operand ALU, multiply/divide, nop and halt instructions. It replaces hand-sequenced control with a registered state machine, and adds a memory-ready wait on fetch.

Parameters:
OPW, 5, opcode field width (IR[31:27])
RFW, 4, register-field width (ra=IR[26:23], rb=IR[22:19], rc=IR[18:15])

Ports:
Clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
IR  in  32  instruction register contents from datapath
mem_ready  in  1  memory read data valid on Mdatain
Stop  in  1  request halt at next instruction boundary
PCout, MARin, IncPC, Zlowin, Zhighin  out  1 each  datapath strobes
Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
LOin, HIin  out  1 each  LO/HI register load
Gra, Grb, Grc, Rin, Rout  out  1 each  register-select field enable and GPR load/drive
opcode  out  5  ALU operation code
Run  out  1  high while not halted
instr_done  out  1  one-cycle pulse on final execute step
illegal  out  1  one-cycle pulse when an undefined opcode is decoded

Behaviour:
- Reset: clear low forces state RST asynchronously. While in RST, every output is 0, including Run=0 and opcode=0. The first rising edge after clear goes high moves RST->T0.
- All outputs are combinational decodes of the registered state and IR[31:27]. Only the state register and the stop latch are sequential.
- T0: PCout, MARin, IncPC, Zlowin, Run. Next state T1.
- T1: Zlowout, PCin, Read, MDRin. Hold T1 while mem_ready=0; PCin pulses only on the first T1 cycle. Go to T2 on mem_ready=1.
- T2: MDRout, IRin. Next state T3.
- T3 decode on IR[31:27]:
  - R-type ALU ops 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol: T3 Grb, Rout, Yin; T4 Grc, Rout, Zlowin, opcode=IR[31:27]; T5 Zlowout, Gra, Rin, instr_done; then T0.
  - 01111 mul, 10000 div: T3 Gra, Rout, Yin; T4 Grb, Rout, Zlowin, Zhighin, opcode=IR[31:27]; T5 Zlowout, LOin; T6 Zhighout, HIin, instr_done; then T0.
  - 11010 nop: T3 asserts instr_done, then T0.
  - 11011 halt: T3 asserts instr_done, then HALT.
  - Any other opcode: T3 asserts illegal and instr_done, then T0 (treated as nop).
- opcode output is 0 in every state except T4.
- Stop: a high level on any edge sets the stop latch. When the latch is set, the transition that would enter T0 goes to HALT instead. In-flight instructions always complete.
- HALT: all outputs 0, Run=0. Only clear low exits HALT. The stop latch clears on reset.
- Boundaries:
  - Reset mid-instruction, including during a T1 wait: aborts immediately with no partial strobes.
  - mem_ready high on the first T1 cycle gives zero wait.
  - Stop and halt opcode in the same instruction give a single HALT entry.
  - Rin and Rout are never high in the same state.

Test Plan:
- Release clear, IR=0x18918000 (add R1,R2,R3), mem_ready=1 -> T0..T5 take 6 cycles. T4 shows opcode=00011 with Grc and Rout. T5 shows Gra, Rin and instr_done. Returns to T0.
- Same add with mem_ready held low 3 cycles in T1 -> Read and MDRin stay high 4 cycles, PCin pulses 1 cycle, total 9 cycles to instr_done.
- IR=0x78000000 (mul) -> T5 LOin with Zlowout, T6 HIin with Zhighout, instr_done in T6, opcode=01111 only in T4.
- IR=0xD8000000 (halt) -> instr_done in T3, then Run=0 and all strobes 0 for 10+ cycles. A clear low pulse restarts at T0.
- IR=0xF8000000 (opcode 11111) -> illegal and instr_done pulse in T3, next cycle T0 with PCout high.
- Assert Stop during T4 of an add -> T5 completes with Gra and Rin, then HALT with no T0. A separate case drops clear during T4: all outputs 0 within the same cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the datapath.
// Runs the fetch steps T0-T2 (with a memory-ready wait in T1), decodes IR[31:27]
// and runs the execute steps T3-T6 for ALU, mul/div, nop and halt instructions.
// Every strobe is a combinational decode of the registered state and the opcode
// field. The only sequential elements are the state register and the stop latch.
module control_sequencer #(
    parameter int OPW = 5,
    parameter int RFW = 4
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    input  logic           Stop,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zlowin,
    output logic           Zhighin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           LOin,
    output logic           HIin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] opcode,
    output logic           Run,
    output logic           instr_done,
    output logic           illegal
);

    localparam int IRW       = 32;
    localparam int FIELD_LSB = IRW - OPW - 3 * RFW;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(10);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    // T1 is split into a first cycle and a wait cycle so that PCin can pulse
    // only once without an extra flag register.
    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    state_t         state;
    logic           stop_q;
    logic [OPW-1:0] op;
    logic           is_alu;
    logic           is_muldiv;
    logic           is_nop;
    logic           is_halt;
    logic           is_legal;
    state_t         boundary;

    // Register-field and immediate bits are consumed by the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^{IR[IRW-OPW-1 -: 3*RFW], IR[FIELD_LSB-1:0]};

    assign op = IR[IRW-1 -: OPW];

    // Opcode class decode
    always_comb begin
        is_alu    = (op >= OP_ADD) && (op <= OP_ROL);
        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
        is_nop    = (op == OP_NOP);
        is_halt   = (op == OP_HALT);
        is_legal  = is_alu || is_muldiv || is_nop || is_halt;
    end

    // Instruction boundary: a latched stop request diverts T0 entry to HALT
    always_comb begin
        boundary = stop_q ? S_HALT : S_T0;
    end

    // State register and stop latch
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state  <= S_RST;
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_q | Stop;
            case (state)
                S_RST:  state <= boundary;
                S_T0:   state <= S_T1;
                S_T1,
                S_T1W:  state <= mem_ready ? S_T2 : S_T1W;
                S_T2:   state <= S_T3;
                S_T3: begin
                    if (is_alu || is_muldiv)
                        state <= S_T4;
                    else if (is_halt)
                        state <= S_HALT;
                    else
                        state <= boundary;
                end
                S_T4:   state <= (is_alu || is_muldiv) ? S_T5 : boundary;
                S_T5:   state <= is_muldiv ? S_T6 : boundary;
                S_T6:   state <= boundary;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Per-state strobe decode; RST and HALT keep every output low
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        opcode     = '0;
        Run        = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_T0: begin
                Run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T1W: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_muldiv) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else begin
                    instr_done = 1'b1;
                    illegal    = !is_legal;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (is_alu) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zlowin = 1'b1;
                    opcode = op;
                end else if (is_muldiv) begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    Zlowin  = 1'b1;
                    Zhighin = 1'b1;
                    opcode  = op;
                end
            end
            S_T5: begin
                Run = 1'b1;
                if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end else if (is_alu) begin
                    Zlowout    = 1'b1;
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_T6: begin
                Run = 1'b1;
                if (is_muldiv) begin
                    Zhighout   = 1'b1;
                    HIin       = 1'b1;
                    instr_done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed cases followed by random
// instructions, memory waits, stop requests and mid-instruction resets, all
// checked against a step-list model of each instruction.
module tb_control_sequencer;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        Stop;
    logic        PCout, MARin, IncPC, Zlowin, Zhighin, Zlowout, Zhighout, PCin;
    logic        Read, MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic        Gra, Grb, Grc, Rin, Rout, Run, instr_done, illegal;
    logic [4:0]  opcode;

    int n_checks = 0;
    int n_errors = 0;
    bit stop_latched = 1'b0;

    control_sequencer #(.OPW(5), .RFW(4)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .opcode(opcode), .Run(Run), .instr_done(instr_done), .illegal(illegal)
    );

    // Observed output vector: bit n matches the masks below, opcode in [27:23]
    logic [27:0] obs;
    assign obs = {opcode, illegal, instr_done, Run, Rout, Rin, Grc, Grb, Gra, HIin, LOin,
                  Yin, IRin, MDRout, MDRin, Read, PCin, Zhighout, Zlowout, Zhighin,
                  Zlowin, IncPC, MARin, PCout};

    localparam logic [27:0] M_PCOUT    = 28'd1 << 0;
    localparam logic [27:0] M_MARIN    = 28'd1 << 1;
    localparam logic [27:0] M_INCPC    = 28'd1 << 2;
    localparam logic [27:0] M_ZLOWIN   = 28'd1 << 3;
    localparam logic [27:0] M_ZHIGHIN  = 28'd1 << 4;
    localparam logic [27:0] M_ZLOWOUT  = 28'd1 << 5;
    localparam logic [27:0] M_ZHIGHOUT = 28'd1 << 6;
    localparam logic [27:0] M_PCIN     = 28'd1 << 7;
    localparam logic [27:0] M_READ     = 28'd1 << 8;
    localparam logic [27:0] M_MDRIN    = 28'd1 << 9;
    localparam logic [27:0] M_MDROUT   = 28'd1 << 10;
    localparam logic [27:0] M_IRIN     = 28'd1 << 11;
    localparam logic [27:0] M_YIN      = 28'd1 << 12;
    localparam logic [27:0] M_LOIN     = 28'd1 << 13;
    localparam logic [27:0] M_HIIN     = 28'd1 << 14;
    localparam logic [27:0] M_GRA      = 28'd1 << 15;
    localparam logic [27:0] M_GRB      = 28'd1 << 16;
    localparam logic [27:0] M_GRC      = 28'd1 << 17;
    localparam logic [27:0] M_RIN      = 28'd1 << 18;
    localparam logic [27:0] M_ROUT     = 28'd1 << 19;
    localparam logic [27:0] M_RUN      = 28'd1 << 20;
    localparam logic [27:0] M_DONE     = 28'd1 << 21;
    localparam logic [27:0] M_ILL      = 28'd1 << 22;

    localparam int K_ALU = 0, K_MD = 1, K_NOP = 2, K_HALT = 3, K_ILL = 4;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_kind(input logic [4:0] op);
        int o;
        o = int'(op);
        if (o >= 3 && o <= 10) return K_ALU;
        if (o == 15 || o == 16) return K_MD;
        if (o == 26) return K_NOP;
        if (o == 27) return K_HALT;
        return K_ILL;
    endfunction

    task automatic do_reset();
        #2 clear = 1'b0;
        Stop = 1'b0;
        #1 check("rst_async", obs, 28'd0);
        @(negedge Clock);
        check("rst_hold", obs, 28'd0);
        clear = 1'b1;
        stop_latched = 1'b0;
    endtask

    // One instruction starting in T0. w = T1 wait cycles, stop_at / abort_at are
    // step indices (-1 = none) at which Stop is raised or clear is pulled low.
    task automatic run_instr(input logic [4:0] op, input int w, input int stop_at,
                             input int abort_at);
        logic [27:0] e[$];
        logic [27:0] opv;
        logic [26:0] low;
        int          k;
        int          len;
        bit          halting;
        bit          carry;
        k   = op_kind(op);
        opv = {op, 23'd0};
        e.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN);
        e.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN);
        for (int j = 0; j < w; j++) e.push_back(M_ZLOWOUT | M_READ | M_MDRIN | M_RUN);
        e.push_back(M_MDROUT | M_IRIN | M_RUN);
        case (k)
            K_ALU: begin
                e.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
                e.push_back(M_GRC | M_ROUT | M_ZLOWIN | M_RUN | opv);
                e.push_back(M_ZLOWOUT | M_GRA | M_RIN | M_DONE | M_RUN);
            end
            K_MD: begin
                e.push_back(M_GRA | M_ROUT | M_YIN | M_RUN);
                e.push_back(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN | M_RUN | opv);
                e.push_back(M_ZLOWOUT | M_LOIN | M_RUN);
                e.push_back(M_ZHIGHOUT | M_HIIN | M_DONE | M_RUN);
            end
            K_ILL:   e.push_back(M_ILL | M_DONE | M_RUN);
            default: e.push_back(M_DONE | M_RUN);
        endcase
        len = e.size();
        // A stop seen on any edge before the last step ends this instruction in HALT;
        // one seen on the final edge only takes effect at the next boundary.
        halting = stop_latched || (k == K_HALT) || (stop_at >= 0 && stop_at <= len - 2);
        carry   = (stop_at == len - 1);
        for (int i = 0; i < len; i++) begin
            @(negedge Clock);
            check($sformatf("op%0d_w%0d_step%0d", op, w, i), obs, e[i]);
            check("rin_rout_excl", {27'd0, Rin & Rout}, 28'd0);
            if (i == abort_at) begin
                #2 clear = 1'b0;
                Stop = 1'b0;
                #1 check($sformatf("abort_step%0d", i), obs, 28'd0);
                @(negedge Clock);
                check("abort_hold", obs, 28'd0);
                clear = 1'b1;
                stop_latched = 1'b0;
                return;
            end
            if (i == 0) begin
                low = 27'($urandom());
                IR  = {op, low};
            end
            if (i >= 1 && i <= 1 + w) mem_ready = (i == 1 + w);
            else mem_ready = 1'($urandom_range(0, 1));
            Stop = (i == stop_at);
        end
        if (halting) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge Clock);
                check($sformatf("halt_cycle%0d", c), obs, 28'd0);
                mem_ready = 1'($urandom_range(0, 1));
                Stop      = 1'($urandom_range(0, 1));
            end
            do_reset();
        end else begin
            stop_latched = carry;
        end
    endtask

    initial begin
        logic [4:0] op;
        int         w;
        int         s;
        int         a;
        clear     = 1'b0;
        IR        = '0;
        mem_ready = 1'b0;
        Stop      = 1'b0;
        @(negedge Clock);
        check("reset_state", obs, 28'd0);
        @(negedge Clock);
        check("reset_state2", obs, 28'd0);
        clear = 1'b1;

        run_instr(5'd3, 0, -1, -1);    // add, zero wait
        run_instr(5'd3, 3, -1, -1);    // add, three wait cycles
        run_instr(5'd15, 0, -1, -1);   // mul
        run_instr(5'd16, 1, -1, -1);   // div
        run_instr(5'd26, 0, -1, -1);   // nop
        run_instr(5'd31, 0, -1, -1);   // undefined opcode
        run_instr(5'd10, 2, -1, -1);   // rol, T0 right after the illegal one
        run_instr(5'd27, 0, -1, -1);   // halt, then reset restarts
        run_instr(5'd3, 0, 4, -1);     // Stop during T4 of add
        run_instr(5'd3, 0, -1, 4);     // clear dropped during T4
        run_instr(5'd4, 2, -1, 2);     // clear dropped during T1 wait
        run_instr(5'd27, 0, 1, -1);    // Stop plus halt opcode
        run_instr(5'd8, 0, -1, -1);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 1) == 0) op = 5'($urandom_range(0, 31));
            else begin
                case ($urandom_range(0, 4))
                    0: op = 5'($urandom_range(3, 10));
                    1: op = 5'($urandom_range(15, 16));
                    2: op = 5'd26;
                    3: op = 5'd27;
                    default: op = 5'($urandom_range(17, 25));
                endcase
            end
            w = $urandom_range(0, 3);
            s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
            a = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, w, s, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
